// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: walks a mux select tree through every index,
// captures each word onto a valid/ready stream and sums the words.
module mux_scan_sequencer #(
    parameter int switch_bits = 2,
    parameter int data_width  = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    output logic [switch_bits-1:0]            sel,
    input  logic [data_width-1:0]             mux_o,
    output logic [data_width-1:0]             out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              out_last,
    output logic [data_width+switch_bits-1:0] acc,
    output logic                              busy,
    output logic                              done
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        HOLD,
        DONE
    } state_t;

    localparam logic [switch_bits-1:0] last_idx = '1;
    localparam logic [switch_bits-1:0] one_idx  = switch_bits'(1);

    state_t                          state;
    state_t                          state_nxt;
    logic [switch_bits-1:0]          idx;
    logic [switch_bits-1:0]          idx_nxt;
    logic                            at_last;
    logic [data_width+switch_bits-1:0] word_ext;

    assign at_last  = (idx == last_idx);
    assign word_ext = {{switch_bits{1'b0}}, mux_o};

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SCAN;
                    idx_nxt   = '0;
                end
            end
            SCAN: begin
                state_nxt = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    if (at_last) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = SCAN;
                        idx_nxt   = idx + one_idx;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            idx      <= '0;
            sel      <= '0;
            out_data <= '0;
            acc      <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            // select moves only on SCAN entry; parked at zero once idle again
            if (state_nxt == SCAN) begin
                sel <= idx_nxt;
            end else if (state == DONE) begin
                sel <= '0;
            end
            if (state == SCAN) begin
                out_data <= mux_o;
                acc      <= acc + word_ext;
            end else if (state == IDLE && start) begin
                acc <= '0;
            end
        end
    end

    assign out_valid = (state == HOLD);
    assign out_last  = (state == HOLD) && at_last;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer with a 4-input mux model.
// Inputs driven and outputs sampled 1ns after the rising edge.
module tb_mux_scan_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] sel;
    logic [7:0] mux_o;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic [9:0] acc;
    logic       busy;
    logic       done;

    logic [7:0] mem  [4];
    logic [7:0] want [4];

    int errors = 0;
    int checks = 0;

    mux_scan_sequencer #(
        .switch_bits(2),
        .data_width (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sel      (sel),
        .mux_o    (mux_o),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last),
        .acc      (acc),
        .busy     (busy),
        .done     (done)
    );

    assign mux_o = mem[sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, " sel"},   32'(sel), 0);
        chk({tag, " data"},  32'(out_data), 0);
        chk({tag, " valid"}, 32'(out_valid), 0);
        chk({tag, " last"},  32'(out_last), 0);
        chk({tag, " acc"},   32'(acc), 0);
        chk({tag, " busy"},  32'(busy), 0);
        chk({tag, " done"},  32'(done), 0);
    endtask

    // One full scan with ready high; optional 5-cycle stall and a
    // start poke during HOLD of the given word index (-1 = none).
    task automatic scan(input string t, input logic [9:0] exp_acc,
                        input int stall_at, input int poke_at);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({t, " busy@T0"}, 32'(busy), 1);
        chk({t, " sel@T0"}, 32'(sel), 0);
        chk({t, " valid@T0"}, 32'(out_valid), 0);
        chk({t, " acc@T0"}, 32'(acc), 0);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk({t, " valid"}, 32'(out_valid), 1);
            chk({t, " data"}, 32'(out_data), 32'(want[k]));
            chk({t, " last"}, 32'(out_last), (k == 3) ? 1 : 0);
            chk({t, " sel"}, 32'(sel), 32'(k));
            if (k == stall_at) begin
                out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    tick();
                    chk({t, " stall valid"}, 32'(out_valid), 1);
                    chk({t, " stall data"}, 32'(out_data), 32'(want[k]));
                    chk({t, " stall sel"}, 32'(sel), 32'(k));
                end
                out_ready = 1'b1;
            end
            if (k == poke_at) start = 1'b1;
            tick();
            start = 1'b0;
            if (k < 3) begin
                chk({t, " gap valid"}, 32'(out_valid), 0);
                chk({t, " gap done"}, 32'(done), 0);
            end
        end
        chk({t, " done"}, 32'(done), 1);
        chk({t, " busy@done"}, 32'(busy), 1);
        chk({t, " acc"}, 32'(acc), 32'(exp_acc));
        tick();
        chk({t, " done drop"}, 32'(done), 0);
        chk({t, " idle busy"}, 32'(busy), 0);
        chk({t, " idle sel"}, 32'(sel), 0);
        tick();
        chk({t, " no restart"}, 32'(busy), 0);
        chk({t, " acc hold"}, 32'(acc), 32'(exp_acc));
        out_ready = 1'b0;
    endtask

    initial begin
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
        want[0] = 8'h11; want[1] = 8'h22; want[2] = 8'h33; want[3] = 8'h44;
        rst = 1'b0;
        start = 1'b0;
        out_ready = 1'b0;
        #22;
        chk_idle_zero("reset");
        tick();
        rst = 1'b1;
        tick();

        scan("basic", 10'h0AA, -1, -1);
        scan("bp", 10'h0AA, 1, -1);
        scan("poke", 10'h0AA, -1, 2);

        // reset mid-scan while holding word 0x22
        start = 1'b1;
        tick();
        start = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        tick();
        chk("mid hold data", 32'(out_data), 32'h22);
        chk("mid hold valid", 32'(out_valid), 1);
        #2;
        rst = 1'b0;
        #1;
        chk_idle_zero("async rst");
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("post rst busy", 32'(busy), 0);
        scan("after rst", 10'h0AA, -1, -1);

        // back-to-back with start held high
        start = 1'b1;
        out_ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            tick();
            chk("b2b busy@T0", 32'(busy), 1);
            chk("b2b acc@T0", 32'(acc), 0);
            for (int k = 0; k < 4; k++) begin
                tick();
                chk("b2b data", 32'(out_data), 32'(want[k]));
                chk("b2b last", 32'(out_last), (k == 3) ? 1 : 0);
                tick();
            end
            chk("b2b done", 32'(done), 1);
            chk("b2b acc", 32'(acc), 32'h0AA);
            tick();
            chk("b2b idle", 32'(busy), 0);
            chk("b2b idle acc", 32'(acc), 32'h0AA);
        end
        start = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();

        // all-ones inputs exercise the widened sum
        for (int i = 0; i < 4; i++) begin
            mem[i] = 8'hFF;
            want[i] = 8'hFF;
        end
        scan("max", 10'h3FC, -1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_scan_sequencer.md
# mux_scan_sequencer

Control stage that sits directly upstream of the `Mux` select tree and directly downstream of its data output. It drives the tree's `q` select lines through every input index in order and registers each selected word. Each captured word is presented on a valid/ready output stream with a last-word marker. It also accumulates a running sum of all scanned words for the neural-net datapath.

## Interface
Parameters:
- `switch_bits`, 2, width of the select bus; the mux tree has 2^switch_bits inputs
- `data_width`, 8, width of each mux data word

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a scan; sampled only in IDLE
- `sel`  out  switch_bits  registered select, connected to `q` of the mux tree
- `mux_o`  in  data_width  combinational output `o` of the mux tree
- `out_data`  out  data_width  captured word
- `out_valid`  out  1  `out_data` is valid
- `out_ready`  in  1  consumer accepts `out_data`
- `out_last`  out  1  qualifies `out_data` as the final index (2^switch_bits-1)
- `acc`  out  data_width+switch_bits  unsigned sum of words accepted in the current or last scan
- `busy`  out  1  high in any state other than IDLE
- `done`  out  1  one-cycle pulse after the final word is accepted

## Operation
States:
- **IDLE**
  - `sel`=0, `out_valid`=0.
  - `start`=1 → SCAN. On this transition: idx←0 and acc←0.
- **SCAN**
  - `sel`=idx, so `mux_o` settles during this cycle.
  - At the clock edge: out_data←mux_o, acc←acc+mux_o, → HOLD.
- **HOLD**
  - `out_valid`=1. `out_last`=(idx==2^switch_bits-1).
  - `out_data` and `sel` stay stable until handshake.
  - `out_valid && out_ready`:
    - if last → DONE;
    - otherwise idx←idx+1 and → SCAN.
  - `out_ready`=0: remain in HOLD indefinitely.
- **DONE**
  - `done`=1 for exactly one cycle, `busy`=1, → IDLE.
  - `acc` holds the final sum until the next accepted `start`.

Rules:
- `start` is ignored in SCAN, HOLD and DONE, and has no queued effect.
- `start` held high continuously gives back-to-back scans: DONE → IDLE → SCAN.
- Arithmetic: `acc` is an unsigned zero-extended sum. The width data_width+switch_bits cannot overflow for a full scan.
- idx is switch_bits wide. It never wraps within a scan; the last index exits through DONE.
- Reset (`rst`=0, asynchronous, at any time including mid-scan):
  - state→IDLE, and idx, sel, out_data, out_valid, out_last, acc, busy, done all →0.
  - The partial scan is abandoned; nothing resumes after reset is released.
- `out_data` only changes on the SCAN→HOLD edge. `out_last` and `out_valid` are zero outside HOLD.

## Timing
- `start` is sampled at edge T0 in IDLE:
  - `busy` and `sel`=0 from T0.
  - First `out_valid` from edge T1.
- With `out_ready` held high, each word costs 2 cycles (SCAN plus HOLD).
- A full scan takes 2·2^switch_bits cycles from `start` to the last handshake, then `done` in the following cycle.
- `sel` is registered and changes only on SCAN entry. The mux path is `sel`→`mux_o`→`out_data`, which is one cycle of combinational settling.
- All outputs are registered or decoded directly from state. There is no combinational path from `out_ready` to `out_valid` or `out_data`.

## Test plan
Configuration: switch_bits=2, data_width=8, bench mux model with inputs {0x11,0x22,0x33,0x44}.
- **Basic scan:** `start` pulse, `out_ready`=1 → `out_data` sequence 0x11,0x22,0x33,0x44, with `out_last` only on 0x44. `done` pulses 1 cycle after the last handshake, `acc`=0x0AA, total 8 cycles from `start` to last handshake.
- **Backpressure:** `out_ready`=0 for 5 cycles during word 0x22 → `out_valid` stays 1 and `out_data`=0x22, `sel`=1 stable. Sequence resumes unchanged and `acc` is still 0x0AA.
- **Max-value sum:** all inputs 0xFF → `acc`=0x3FC, no truncation.
- **Ignored start:** `start` re-asserted during HOLD of word 0x33 → no restart, sequence completes normally, exactly one `done` pulse.
- **Reset mid-scan:** `rst`=0 asynchronously while in HOLD on 0x22 → all outputs 0 immediately, without waiting for a clock edge. After release and a new `start`, the sequence begins again at 0x11 with `acc`=0.
- **Back-to-back scans:** `start` held high → second scan begins one cycle after `done`, and `acc` restarts from 0 to reach 0x0AA again.
